ets_sweep_engine: RTL

ETS_SWEEP_ENGINE -- requirements
Module: ets_sweep_engine

---
 rtl/ets_sweep_engine_if.sv | 25 ++
 rtl/ets_sweep_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ets_sweep_engine_if.sv
// Phase-shift handshake and sample-memory write port of the ETS sweep engine.
// The engine drives the master side; the MMCM / buffer logic sits on the slave side.
interface ets_sweep_engine_if #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 9
);
    logic                    ps_en;
    logic                    ps_incdec;
    logic                    ps_done;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [N_CH*CNT_W-1:0]   wr_data;
    logic                    wr_bank;

    modport master (
        output ps_en, ps_incdec, wr_en, wr_addr, wr_data, wr_bank,
        input  ps_done
    );

    modport slave (
        input  ps_en, ps_incdec, wr_en, wr_addr, wr_data, wr_bank,
        output ps_done
    );
endinterface

// File: rtl/ets_sweep_engine.sv
// Equivalent-time sampling sweep: accumulate comparator hits per phase point,
// write them out, then step the MMCM phase; serpentine in continuous mode.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for en; latches avg_count and resets point index
// ACCUM     | counting triggers, summing cmp_data into per-channel accs
// WRITE     | wr_en high for one cycle with the finished point
// SHIFT     | ps_en high for one cycle toward dir
// WAIT_DONE | waiting for ps_done, bounded by TIMEOUT
// END_SWEEP | sweep_done pulse, bank flip, optional direction reversal
module ets_sweep_engine #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16,
    parameter int PHASE_STEPS = 448,
    parameter int ADDR_W      = 9,
    parameter int STEP_INC    = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     mode_cont,
    input  logic [CNT_W-1:0]         avg_count,
    input  logic                     trigger,
    input  logic [N_CH-1:0]          cmp_data,
    ets_sweep_engine_if.master       bus,
    output logic                     busy,
    output logic                     sweep_done,
    output logic signed [31:0]       phase_counter,
    output logic                     timeout_err
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int PL_W = $clog2(STEP_INC + 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        WRITE,
        SHIFT,
        WAIT_DONE,
        END_SWEEP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] point_idx;
    logic              dir;
    logic [CNT_W-1:0]  avg_lat;
    logic [CNT_W-1:0]  trig_cnt;
    logic [CNT_W-1:0]  acc [N_CH];
    logic [TO_W-1:0]   wait_cnt;
    logic [PL_W-1:0]   pulses_left;
    logic [CNT_W-1:0]  avg_eff;
    logic              last_point;

    assign avg_eff    = (avg_count == '0) ? CNT_W'(1) : avg_count;
    assign last_point = dir ? (point_idx == ADDR_W'(PHASE_STEPS - 1)) : (point_idx == '0);
    assign busy       = (state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.ps_en     <= 1'b0;
            bus.ps_incdec <= 1'b1;
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.wr_bank   <= 1'b0;
            sweep_done    <= 1'b0;
            phase_counter <= '0;
            timeout_err   <= 1'b0;
            point_idx     <= '0;
            dir           <= 1'b1;
            avg_lat       <= '0;
            trig_cnt      <= '0;
            wait_cnt      <= '0;
            pulses_left   <= '0;
            for (int i = 0; i < N_CH; i++) acc[i] <= '0;
        end else begin
            // single-cycle strobes fall back low unless re-armed below
            bus.ps_en  <= 1'b0;
            bus.wr_en  <= 1'b0;
            sweep_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (en) begin
                        point_idx <= '0;
                        dir       <= 1'b1;
                        avg_lat   <= avg_eff;
                        trig_cnt  <= '0;
                        for (int i = 0; i < N_CH; i++) acc[i] <= '0;
                        state     <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (trig_cnt == avg_lat) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= point_idx;
                        for (int i = 0; i < N_CH; i++) bus.wr_data[i*CNT_W +: CNT_W] <= acc[i];
                        state       <= WRITE;
                    end else if (trigger) begin
                        trig_cnt <= trig_cnt + CNT_W'(1);
                        for (int i = 0; i < N_CH; i++) begin
                            if (cmp_data[i] && (acc[i] != '1)) acc[i] <= acc[i] + CNT_W'(1);
                        end
                    end
                end

                WRITE: begin
                    trig_cnt <= '0;
                    for (int i = 0; i < N_CH; i++) acc[i] <= '0;
                    if (!en) begin
                        state <= IDLE;
                    end else if (last_point) begin
                        sweep_done  <= 1'b1;
                        bus.wr_bank <= ~bus.wr_bank;
                        state       <= END_SWEEP;
                    end else begin
                        bus.ps_en     <= 1'b1;
                        bus.ps_incdec <= dir;
                        pulses_left   <= PL_W'(STEP_INC - 1);
                        state         <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= TO_W'(TIMEOUT - 1);
                        state    <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (bus.ps_done) begin
                        phase_counter <= dir ? (phase_counter + 32'sd1) : (phase_counter - 32'sd1);
                        if (!en) begin
                            state <= IDLE;
                        end else if (pulses_left == '0) begin
                            point_idx <= dir ? (point_idx + ADDR_W'(1)) : (point_idx - ADDR_W'(1));
                            state     <= ACCUM;
                        end else begin
                            pulses_left <= pulses_left - PL_W'(1);
                            bus.ps_en   <= 1'b1;
                            state       <= SHIFT;
                        end
                    end else if (wait_cnt == '0) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - TO_W'(1);
                    end
                end

                END_SWEEP: begin
                    // serpentine: the next sweep starts from the point just written
                    if (mode_cont && en) begin
                        dir     <= ~dir;
                        avg_lat <= avg_eff;
                        state   <= ACCUM;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
